// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter sharing the regfile write port between the
//            ALU writeback (A) and the load return path (B). Registers the
//            write port, discards writes to r0, and keeps saturating
//            committed-write / dropped-write statistics.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic [CW-1:0] wr_count,
  output logic [7:0]    drop_count
);

  // rr_ptr names the requester granted most recently; the other one wins
  // the next contention.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  logic          rr_ptr_q, rr_ptr_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic [CW-1:0] wr_count_q, wr_count_d;
  logic [7:0]    drop_count_q, drop_count_d;

  logic          w_grant_a, w_grant_b, w_xfer;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_data;
  logic          w_is_r0;

  // Grant: a lone requester is always served; under contention the one not
  // named by rr_ptr wins. Nothing is granted while reset is asserted.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!reset) begin
      w_grant_a = a_valid && (!b_valid || (rr_ptr_q == RR_B));
      w_grant_b = b_valid && (!a_valid || (rr_ptr_q == RR_A));
    end
  end

  assign a_ready    = w_grant_a;
  assign b_ready    = w_grant_b;
  assign w_xfer     = w_grant_a | w_grant_b;
  assign w_sel_addr = w_grant_b ? b_addr : a_addr;
  assign w_sel_data = w_grant_b ? b_data : a_data;
  assign w_is_r0    = (w_sel_addr == '0);

  // Next-state: pointer, write stage and saturating statistics.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    we3_d        = 1'b0;
    wa3_d        = wa3_q;
    wd3_d        = wd3_q;
    wr_count_d   = wr_count_q;
    drop_count_d = drop_count_q;
    if (w_xfer) begin
      rr_ptr_d = w_grant_b ? RR_B : RR_A;
      wa3_d    = w_sel_addr;
      wd3_d    = w_sel_data;
      we3_d    = !w_is_r0;
      if (!w_is_r0) begin
        if (wr_count_q != {CW{1'b1}}) wr_count_d = wr_count_q + 1'b1;
      end else begin
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  // State register; asynchronous reset cancels any write in the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= RR_B;
      we3_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      we3_q        <= we3_d;
      wa3_q        <= wa3_d;
      wd3_q        <= wd3_d;
      wr_count_q   <= wr_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign we3        = we3_q;
  assign wa3        = wa3_q;
  assign wd3        = wd3_q;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters: A (ALU result path) and B (load/memory return path).
Each requester uses a valid/ready handshake. Contention is resolved round-robin. The write-port signals are registered, and writes to register 0 are filtered out.
Saturating statistics counters support debug and verification. The block sits directly in front of the regfile write port.

Parameters:
DW, 32, data width of the write port (matches wd3)
AW, 5, register address width (matches wa3)
CW, 16, width of the committed-write counter

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
a_valid  input  1  requester A has a write pending
a_addr  input  AW  requester A destination register
a_data  input  DW  requester A write data
a_ready  output  1  A's request is accepted this cycle (combinational)
b_valid  input  1  requester B has a write pending
b_addr  input  AW  requester B destination register
b_data  input  DW  requester B write data
b_ready  output  1  B's request is accepted this cycle (combinational)
we3  output  1  regfile write enable (registered)
wa3  output  AW  regfile write address (registered)
wd3  output  DW  regfile write data (registered)
wr_count  output  CW  committed (non-r0) writes, saturating
drop_count  output  8  accepted writes to r0 that were discarded, saturating

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
  - Reset clears we3, wa3, wd3, wr_count, drop_count and rr_ptr.
  - rr_ptr resets to B, so A wins the first contention.
  - a_ready and b_ready are forced to 0 while reset is high.
- Handshake: a transfer occurs on a rising edge where valid && ready.
  - Requesters hold valid, addr and data stable until ready.
  - ready never depends on the requester's own ready, only on the valids, rr_ptr and reset.
- Grant (combinational):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the requester that is not rr_ptr.
  - Neither valid: both readys are 0.
  - At most one ready is high per cycle.
- Pointer: rr_ptr loads the granted requester on every transfer; it holds when there is no transfer.
  - Under continuous contention, grants therefore strictly alternate A, B, A, B.
  - No requester waits more than 1 cycle while contended.
- Write stage, one register stage, latency 1:
  - On the edge where a transfer occurs, wa3 and wd3 load the granted addr and data.
  - On that same edge, we3 loads 1 if addr != 0, otherwise 0.
  - On any edge with no transfer, we3 loads 0; wa3 and wd3 hold their last value.
  - we3 is high for exactly one cycle per committed write.
  - The regfile captures on the following edge, so data is readable via rd1/rd2 two edges after acceptance.
- Back-to-back transfers on consecutive cycles are supported at full rate: one write per cycle, with no bubbles required.
- r0 filter: a transfer with addr==0 is accepted (ready=1) but we3 stays 0, and drop_count increments. The regfile's r0 stays zero independently of this block.
- Counters:
  - wr_count increments on each edge that loads we3=1.
  - drop_count increments on each r0 drop.
  - Both saturate at all-ones and never wrap.
- Same-address contention: A and B targeting the same register is resolved purely by grant order. The later-granted write lands one cycle later and is the final value. No merging or reordering is performed.
- Reset mid-operation:
  - A write sitting in the output stage (we3=1) is cancelled immediately; the regfile does not see it on the next edge.
  - Requests that were presented but not yet accepted are not lost by this block; requesters re-present them after reset.

Test Plan:
- Reset, then A writes addr=3, data=0x0000_0003 -> a_ready=1 that cycle; next cycle we3=1, wa3=3, wd3=3; regfile rd1 on ra1=3 reads 3 one edge later; wr_count=1.
- A and B valid together for 4 cycles (A: addr 1, data 0x11; B: addr 2, data 0x22) -> grants A, B, A, B; we3 high for 4 consecutive cycles with wa3 sequence 1, 2, 1, 2.
- B alone writes addr=0, data=0x1 -> b_ready=1; we3 stays 0; drop_count=1; wr_count unchanged; regfile r0 reads 0.
- A and B both target addr=5 (A 0x7, B 0x5), simultaneous first contention after reset -> A committed first, then B; r5 finally reads 0x5.
- Assert reset asynchronously mid-cycle while we3=1 (addr=4, data=0xAA) -> we3, wa3, wd3 and the counters go to 0 immediately; r4 is not written; a_ready and b_ready stay 0 until reset is released.
- Force 2^CW+3 writes to addr=1 -> wr_count saturates at 0xFFFF and does not wrap.
